// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Step-counter width; it must hold WORD_WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned word_width);
    return (word_width < 2) ? 1 : $clog2(word_width);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One combinational multiply step: conditional add of the multiplicand into hi,
// then a logical right shift of {carry, sum, lo} by one.
module mul_step #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] mcand_i,
  input  logic [WORD_WIDTH-1:0] hi_i,
  input  logic [WORD_WIDTH-1:0] lo_i,
  output logic [WORD_WIDTH-1:0] hi_o,
  output logic [WORD_WIDTH-1:0] lo_o
);

  logic [WORD_WIDTH-1:0] addend;
  logic [WORD_WIDTH-1:0] sum;
  logic                  carry;

  assign addend = lo_i[0] ? mcand_i : '0;

  ripple_carry_adder #(
    .WIDTH(WORD_WIDTH)
  ) u_adder (
    .a_i  (hi_i),
    .b_i  (addend),
    .c_i  (1'b0),
    .sum_o(sum),
    .c_o  (carry)
  );

  assign hi_o = {carry, sum[WORD_WIDTH-1:1]};
  assign lo_o = {sum[0], lo_i[WORD_WIDTH-1:1]};

endmodule

// File: rtl/ripple_carry_adder.sv
// Team ripple-carry adder: WIDTH-bit sum with carry-in and carry-out.
module ripple_carry_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
);

  always_comb begin : ripple
    logic [WIDTH:0] carry;
    carry    = '0;
    carry[0] = c_i;
    sum_o    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = carry[WIDTH];
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned multiplier, one add-and-shift step per clock.
// Optional SHIFT_ADD_MUL_ZERO_BYPASS_EN: zero operands skip straight to DONE.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [WORD_WIDTH-1:0]   a_i,
  input  logic [WORD_WIDTH-1:0]   b_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [2*WORD_WIDTH-1:0] product_o,
  output logic                    busy_o
);

  localparam int unsigned CNT_W  = cnt_width(WORD_WIDTH);
  localparam int unsigned PROD_W = 2 * WORD_WIDTH;

  mul_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]   mcand_q, mcand_d;
  logic [WORD_WIDTH-1:0]   hi_q, hi_d;
  logic [WORD_WIDTH-1:0]   lo_q, lo_d;
  logic [PROD_W-1:0]       product_q, product_d;
  logic                    valid_q, valid_d;
  logic [WORD_WIDTH-1:0]   step_hi;
  logic [WORD_WIDTH-1:0]   step_lo;

  mul_step #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_step (
    .mcand_i(mcand_q),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      product_q <= product_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state: accept in IDLE, step in BUSY, hold the product until taken in DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    product_d = product_q;
    valid_d   = valid_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          mcand_d = a_i;
          hi_d    = '0;
          lo_d    = b_i;
          cnt_d   = CNT_W'(WORD_WIDTH - 1);
          state_d = BUSY;
`ifdef SHIFT_ADD_MUL_ZERO_BYPASS_EN
          if ((a_i == '0) || (b_i == '0)) begin
            state_d   = DONE;
            product_d = '0;
            valid_d   = 1'b1;
          end
`else
`endif
        end
      end
      BUSY: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == '0) begin
          state_d   = DONE;
          product_d = {step_hi, step_lo};
          valid_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign ready_o   = (state_q == IDLE);
  assign busy_o    = (state_q == BUSY);
  assign valid_o   = valid_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WORD_WIDTH=8).
module tb_shift_add_multiplier;

  localparam int unsigned W = 8;
`ifdef SHIFT_ADD_MUL_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 8;
`endif

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           valid_i;
  logic           ready_o;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           valid_o;
  logic           ready_i;
  logic [2*W-1:0] product_o;
  logic           busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  shift_add_multiplier #(.WORD_WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .product_o(product_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Waits for valid_o, returning edges elapsed since the caller's last tick.
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_o && n < 40) begin
      tick();
      n++;
    end
  endtask

  // One operation: accept, check latency and product, hold for `hold` cycles, then drain.
  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [2*W-1:0] exp, input int lat, input int hold);
    int n;
    chk({tag, "_ready_pre"}, 32'(ready_o), 32'd1);
    ready_i = (hold == 0);
    a_i     = a;
    b_i     = b;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    a_i     = W'($urandom);
    b_i     = W'($urandom);
    chk({tag, "_busy"}, 32'(busy_o), 32'(lat != 0));
    wait_valid(n);
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_product"}, 32'(product_o), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(valid_o), 32'd1);
      chk({tag, "_hold_product"}, 32'(product_o), 32'(exp));
    end
    ready_i = 1'b1;
    tick();
    chk({tag, "_valid_drop"}, 32'(valid_o), 32'd0);
    chk({tag, "_ready_back"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    int n;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    a_i     = '0;
    b_i     = '0;
    #12;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_product", 32'(product_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    op("basic", 8'd13, 8'd11, 16'h008F, 8, 0);
    op("max", 8'd255, 8'd255, 16'hFE01, 8, 0);
    op("pow2", 8'd128, 8'd2, 16'h0100, 8, 0);
    op("bkpr", 8'd200, 8'd3, 16'h0258, 8, 5);

    // valid_i held with new operands while busy must not disturb the running op
    a_i = 8'd10; b_i = 8'd10; valid_i = 1'b1;
    tick();
    a_i = 8'd7; b_i = 8'd7;
    chk("ign_ready_low", 32'(ready_o), 32'd0);
    wait_valid(n);
    chk("ign_latency", 32'(n), 32'd8);
    chk("ign_product", 32'(product_o), 32'h0064);
    tick();
    chk("ign_ready_back", 32'(ready_o), 32'd1);
    chk("ign_no_reaccept", 32'(busy_o), 32'd0);
    tick();
    valid_i = 1'b0;
    chk("ign2_busy", 32'(busy_o), 32'd1);
    wait_valid(n);
    chk("ign2_latency", 32'(n), 32'd8);
    chk("ign2_product", 32'(product_o), 32'h0031);
    tick();

    // reset mid-operation discards the partial result
    a_i = 8'd50; b_i = 8'd50; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_ni = 1'b0;
    #1;
    chk("mrst_ready", 32'(ready_o), 32'd1);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_valid", 32'(valid_o), 32'd0);
    chk("mrst_product", 32'(product_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    wait_valid(n);
    chk("mrst_no_valid", 32'(valid_o), 32'd0);
    op("after_rst", 8'd2, 8'd3, 16'h0006, 8, 0);

    op("zero", 8'd0, 8'd200, 16'h0000, ZERO_LAT, 0);
    op("zero_b", 8'd9, 8'd0, 16'h0000, ZERO_LAT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
